// File: rtl/tmr_multi_pkg.sv
// tmr_multi_pkg: register map, register layouts and channel state for the multi-channel timer
package tmr_multi_pkg;
  localparam logic [9:0] CH_STRIDE = 10'h010;
  localparam logic [9:0] CR_OFF    = 10'h000;
  localparam logic [9:0] SR_OFF    = 10'h004;
  localparam logic [9:0] CNTR_OFF  = 10'h008;
  localparam logic [9:0] CMPR_OFF  = 10'h00C;
  localparam logic [9:0] IRQ_PEND  = 10'h100;
  // psc field sized for the widest prescaler; narrower builds read the upper bits as 0
  typedef struct packed {
    logic [7:0]  rsvd_hi;
    logic [15:0] psc;
    logic [3:0]  rsvd_lo;
    logic        ie;
    logic        sngl;
    logic        hlt;
    logic        trg;
  } cr_t;
  typedef struct packed {
    logic [29:0] rsvd;
    logic        act;
    logic        mtch;
  } sr_t;
  typedef enum logic {IDLE, RUN} ch_state_t;
endpackage

// File: rtl/tmr_multi_channel.sv
// tmr_multi_channel: one timer channel with prescaler, counter, compare and IDLE/RUN control
//   clk/rst          clock, synchronous active-high reset
//   trg_i/hlt_i      start(restart)/stop requests, hlt wins when both are set
//   sngl_i           single-shot mode
//   psc_i/cmpr_i     prescaler reload and compare value
//   cntr_we_i/_wdata_i  counter overwrite from the bus
//   cnt_o/active_o/match_o  counter value, RUN state, one-cycle match pulse
module tmr_multi_channel
  import tmr_multi_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned PSC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trg_i,
  input  logic                 hlt_i,
  input  logic                 sngl_i,
  input  logic [PSC_WIDTH-1:0] psc_i,
  input  logic [CNT_WIDTH-1:0] cmpr_i,
  input  logic                 cntr_we_i,
  input  logic [CNT_WIDTH-1:0] cntr_wdata_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 active_o,
  output logic                 match_o
);
  ch_state_t            state_q, state_d;
  logic [PSC_WIDTH-1:0] psc_q, psc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 run, restart, tick;
  // a halt freezes prescaler and counter in the cycle it arrives
  assign run      = state_q == RUN && !hlt_i;
  assign restart  = trg_i && !hlt_i;
  // exact compare: a prescaler left above a lowered psc free-runs to its natural wrap
  assign tick     = run && psc_q == psc_i;
  assign match_o  = tick && cnt_q == cmpr_i;
  assign cnt_o    = cnt_q;
  assign active_o = state_q == RUN;
  always_comb begin
    state_d = hlt_i ? IDLE : trg_i ? RUN : (match_o && sngl_i) ? IDLE : state_q;
    psc_d   = (restart || tick) ? '0 : run ? psc_q + PSC_WIDTH'(1) : psc_q;
    cnt_d   = cntr_we_i ? cntr_wdata_i : (restart || match_o) ? '0 : tick ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      psc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      psc_q   <= psc_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/tmr_multi.sv
// tmr_multi: multi-channel timer peripheral on the Ibex data bus
//   clk/rst     clock, synchronous active-high reset
//   irq         per-channel interrupt, sticky match gated by the channel's ie
//   data_*      Ibex data bus slave: gnt same cycle, rvalid/rdata one cycle later, err tied 0
module tmr_multi
  import tmr_multi_pkg::*;
#(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned PSC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  output logic [CHANNELS-1:0] irq,
  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [3:0]          data_be_i,
  input  logic [31:0]         data_addr_i,
  input  logic [31:0]         data_wdata_i,
  output logic                data_gnt_o,
  output logic                data_rvalid_o,
  output logic [31:0]         data_rdata_o,
  output logic                data_err_o
);
  logic [CHANNELS-1:0]  trg_q, trg_d, hlt_q, hlt_d, sngl_q, sngl_d, ie_q, ie_d, mtch_q, mtch_d;
  logic [CHANNELS-1:0]  ch_hit, cntr_we, act, match;
  logic [PSC_WIDTH-1:0] psc_q [CHANNELS];
  logic [PSC_WIDTH-1:0] psc_d [CHANNELS];
  logic [CNT_WIDTH-1:0] cmpr_q [CHANNELS];
  logic [CNT_WIDTH-1:0] cmpr_d [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt [CHANNELS];
  logic                 wr, rvalid_q, unused_bus;
  logic [9:0]           off;
  logic [31:0]          rdata_q, rdata_d;
  cr_t                  wcr, rcr;
  sr_t                  rsr;
  assign wr            = data_req_i && data_we_i;
  assign off           = {6'b0, data_addr_i[3:2], 2'b0};
  assign wcr           = cr_t'(data_wdata_i);
  assign irq           = mtch_q & ie_q;
  assign data_gnt_o    = data_req_i;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = 1'b0;
  assign unused_bus    = ^{data_be_i, data_addr_i[31:10], data_addr_i[1:0], wcr};
  genvar c;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_ch
      assign ch_hit[c] = {data_addr_i[9:4], 4'b0} == CH_STRIDE * 10'(c);
      tmr_multi_channel #(.CNT_WIDTH(CNT_WIDTH), .PSC_WIDTH(PSC_WIDTH)) u_ch (
        .clk          (clk),
        .rst          (rst),
        .trg_i        (trg_q[c]),
        .hlt_i        (hlt_q[c]),
        .sngl_i       (sngl_q[c]),
        .psc_i        (psc_q[c]),
        .cmpr_i       (cmpr_q[c]),
        .cntr_we_i    (cntr_we[c]),
        .cntr_wdata_i (data_wdata_i[CNT_WIDTH-1:0]),
        .cnt_o        (cnt[c]),
        .active_o     (act[c]),
        .match_o      (match[c])
      );
    end
  endgenerate
  always_comb begin
    trg_d   = '0;
    hlt_d   = '0;
    sngl_d  = sngl_q;
    ie_d    = ie_q;
    psc_d   = psc_q;
    cmpr_d  = cmpr_q;
    cntr_we = '0;
    mtch_d  = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      if (wr && ch_hit[n] && off == CR_OFF) begin
        trg_d[n]  = wcr.trg;
        hlt_d[n]  = wcr.hlt;
        sngl_d[n] = wcr.sngl;
        ie_d[n]   = wcr.ie;
        psc_d[n]  = wcr.psc[PSC_WIDTH-1:0];
      end
      if (wr && ch_hit[n] && off == CMPR_OFF) cmpr_d[n] = data_wdata_i[CNT_WIDTH-1:0];
      cntr_we[n] = wr && ch_hit[n] && off == CNTR_OFF;
      // a match in the same cycle as a W1C keeps the flag set so no event is lost
      mtch_d[n]  = match[n] || (mtch_q[n] && !(wr && ch_hit[n] && off == SR_OFF && data_wdata_i[0]));
    end
  end
  always_comb begin
    rcr     = '0;
    rsr     = '0;
    rdata_d = {data_addr_i[9:2], 2'b0} == IRQ_PEND ? 32'(irq) : '0;
    for (int n = 0; n < CHANNELS; n++) begin
      if (ch_hit[n]) begin
        rcr.trg  = trg_q[n];
        rcr.hlt  = hlt_q[n];
        rcr.sngl = sngl_q[n];
        rcr.ie   = ie_q[n];
        rcr.psc  = 16'(psc_q[n]);
        rsr.mtch = mtch_q[n];
        rsr.act  = act[n];
        rdata_d  = off == CR_OFF ? 32'(rcr) : off == SR_OFF ? 32'(rsr) :
                   off == CNTR_OFF ? 32'(cnt[n]) : 32'(cmpr_q[n]);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      trg_q    <= '0;
      hlt_q    <= '0;
      sngl_q   <= '0;
      ie_q     <= '0;
      mtch_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        psc_q[n]  <= '0;
        cmpr_q[n] <= '0;
      end
    end else begin
      trg_q    <= trg_d;
      hlt_q    <= hlt_d;
      sngl_q   <= sngl_d;
      ie_q     <= ie_d;
      mtch_q   <= mtch_d;
      psc_q    <= psc_d;
      cmpr_q   <= cmpr_d;
      rvalid_q <= data_req_i;
      rdata_q  <= (data_req_i && !data_we_i) ? rdata_d : '0;
    end
  end
endmodule

// File: tb/tb_tmr_multi.sv
// tb_tmr_multi: self-checking bench for tmr_multi with a read-data scoreboard
module tb_tmr_multi;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [3:0]  be = 4'hF;
  logic [31:0] addr = '0, wdata = '0;
  logic        gnt, rvalid, err, gnt2, rvalid2, err2;
  logic [31:0] rdata, rdata2;
  logic [3:0]  irq;
  logic [1:0]  irq2;
  logic        sel2 = 1'b0, sb_tag = 1'b0, was_rd = 1'b0, rvm;
  logic [31:0] rdm;
  int          checks = 0, errors = 0;
  typedef struct {
    string       nm;
    logic [31:0] v;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  tmr_multi dut (
    .clk(clk), .rst(rst), .irq(irq),
    .data_req_i(req), .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
    .data_gnt_o(gnt), .data_rvalid_o(rvalid), .data_rdata_o(rdata), .data_err_o(err)
  );
  tmr_multi #(.CHANNELS(2), .CNT_WIDTH(8), .PSC_WIDTH(8)) dut2 (
    .clk(clk), .rst(rst), .irq(irq2),
    .data_req_i(req), .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
    .data_gnt_o(gnt2), .data_rvalid_o(rvalid2), .data_rdata_o(rdata2), .data_err_o(err2)
  );

  always #5 clk = ~clk;
  assign rvm = sel2 ? rvalid2 : rvalid;
  assign rdm = sel2 ? rdata2 : rdata;

  always @(posedge clk) was_rd <= req && !we && sb_tag;
  always @(negedge clk) begin
    if (was_rd) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra rdata %h with nothing expected", rdm);
      end else begin
        e = exp_q.pop_front();
        if (rvm !== 1'b1 || rdm !== e.v) begin
          errors++;
          $display("FAIL %s rvalid %b rdata %h expected %h", e.nm, rvm, rdm, e.v);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic reset_dut;
    rst = 1'b1;
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    sb_tag = 1'b0; req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1 req = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] v, input string nm);
    exp_t x;
    x.nm = nm;
    x.v  = v;
    exp_q.push_back(x);
    sb_tag = 1'b1; req = 1'b1; we = 1'b0; addr = a;
    @(posedge clk);
    #1 req = 1'b0; sb_tag = 1'b0;
  endtask

  task automatic rd_raw(input logic [31:0] a, output logic [31:0] v);
    sb_tag = 1'b0; req = 1'b1; we = 1'b0; addr = a;
    @(posedge clk);
    #1 req = 1'b0;
    v = rdm;
  endtask

  task automatic chk_irq(input logic [3:0] exp, input string nm);
    checks++;
    if (irq !== exp) begin
      errors++;
      $display("FAIL %s irq %b expected %b", nm, irq, exp);
    end
  endtask

  task automatic test_reset;
    reset_dut();
    checks++;
    if (irq !== 4'b0 || rvalid !== 1'b0 || rdata !== 32'b0 || gnt !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs irq %b rvalid %b rdata %h gnt %b err %b expected all 0", irq, rvalid, rdata, gnt, err);
    end
    for (int n = 0; n < 4; n++)
      for (int r = 0; r < 4; r++) rd(32'(16 * n + 4 * r), 32'h0, "reset_reg");
    rd(32'h100, 32'h0, "reset_irq_pend");
    wr(32'h104, 32'hFFFF_FFFF);
    wr(32'h200, 32'hFFFF_FFFF);
    rd(32'h104, 32'h0, "unmapped_104");
    rd(32'h200, 32'h0, "unmapped_200");
    rd(32'h000, 32'h0, "no_alias_cr0");
    idle(1);
    req = 1'b1; we = 1'b1; addr = 32'h0C; wdata = 32'h0;
    #1;
    checks++;
    if (gnt !== 1'b1) begin
      errors++;
      $display("FAIL gnt_same_cycle gnt %b expected 1", gnt);
    end
    @(posedge clk);
    #1 req = 1'b0; we = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL rvalid_after_write rvalid %b err %b expected 1 0", rvalid, err);
    end
    idle(1);
    checks++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rvalid_single_pulse rvalid %b expected 0", rvalid);
    end
  endtask

  task automatic test_periodic;
    reset_dut();
    wr(32'h0C, 32'd3);
    wr(32'h00, 32'h9);
    for (int k = 1; k <= 12; k++) begin
      rd(32'h08, k == 1 ? 32'h0 : 32'((k - 2) % 4), "cnt_periodic");
      chk_irq({3'b0, k >= 5}, "irq_periodic");
    end
    idle(1);
    wr(32'h04, 32'h1);
    chk_irq(4'b0, "irq_w1c");
    for (int k = 15; k <= 18; k++) begin
      rd(32'h04, k == 18 ? 32'h3 : 32'h2, "sr_periodic");
      chk_irq({3'b0, k >= 17}, "irq_reset_after_w1c");
    end
  endtask

  task automatic test_single;
    reset_dut();
    wr(32'h2C, 32'd2);
    wr(32'h20, 32'h20D);
    idle(3);
    rd(32'h24, 32'h2, "sngl_act");
    idle(4);
    rd(32'h24, 32'h2, "sngl_before_match");
    chk_irq(4'b0, "sngl_irq_before");
    rd(32'h24, 32'h2, "sngl_match_edge");
    chk_irq(4'b0100, "sngl_irq_after");
    rd(32'h24, 32'h1, "sngl_done");
    rd(32'h28, 32'h0, "sngl_cntr");
    rd(32'h100, 32'h4, "sngl_irq_pend");
    wr(32'h24, 32'h1);
    wr(32'h20, 32'h205);
    idle(15);
    rd(32'h24, 32'h1, "sngl_noie_sr");
    rd(32'h100, 32'h0, "sngl_noie_pend");
    rd(32'h28, 32'h0, "sngl_noie_cntr");
    chk_irq(4'b0, "sngl_noie_irq");
  endtask

  task automatic test_halt;
    logic [31:0] v;
    bit          found = 1'b0;
    reset_dut();
    wr(32'h1C, 32'd100);
    wr(32'h10, 32'h1401);
    for (int i = 0; i < 400 && !found; i++) begin
      rd_raw(32'h18, v);
      found = v == 32'd5;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL halt_reach_5 cntr %h expected 00000005 within bound", v);
    end
    wr(32'h10, 32'h1402);
    idle(40);
    rd(32'h18, 32'd5, "halt_cntr_hold");
    rd(32'h14, 32'h0, "halt_sr");
    rd(32'h10, 32'h1400, "halt_cr_selfclear");
  endtask

  task automatic test_trg_hlt;
    reset_dut();
    wr(32'h3C, 32'd1000);
    wr(32'h30, 32'h3);
    idle(5);
    rd(32'h34, 32'h0, "trghlt_sr");
    rd(32'h38, 32'h0, "trghlt_cntr");
    rd(32'h30, 32'h0, "trghlt_cr");
  endtask

  task automatic test_retrigger;
    reset_dut();
    wr(32'h1C, 32'd1000);
    wr(32'h10, 32'h1);
    idle(20);
    rd(32'h18, 32'd19, "retrg_before");
    wr(32'h10, 32'h1);
    idle(1);
    for (int k = 0; k < 3; k++) rd(32'h18, 32'(k), "retrg_after");
    rd(32'h14, 32'h2, "retrg_act");
  endtask

  task automatic test_wrap;
    reset_dut();
    wr(32'h0C, 32'd10);
    wr(32'h00, 32'h1);
    idle(1);
    wr(32'h08, 32'hFFFF_FFFF);
    rd(32'h08, 32'hFFFF_FFFF, "wrap_written");
    rd(32'h08, 32'h0, "wrap_zero");
    rd(32'h04, 32'h2, "wrap_no_match");
    rd(32'h08, 32'd2, "wrap_counting");
    idle(7);
    wr(32'h04, 32'h1);
    rd(32'h04, 32'h3, "w1c_vs_match");
    rd(32'h08, 32'd1, "wrap_after_match");
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    rd(32'h04, 32'h0, "midreset_sr");
    rd(32'h08, 32'h0, "midreset_cntr");
    rd(32'h0C, 32'h0, "midreset_cmpr");
    rd(32'h00, 32'h0, "midreset_cr");
    chk_irq(4'b0, "midreset_irq");
  endtask

  task automatic test_small;
    sel2 = 1'b1;
    reset_dut();
    wr(32'h08, 32'hFFFF_FF7F);
    wr(32'h0C, 32'h1234_5678);
    wr(32'h20, 32'hFFFF_FFFF);
    wr(32'h2C, 32'h5);
    wr(32'h00, 32'hFFFF_FFF0);
    rd(32'h08, 32'h7F, "small_cntr_upper");
    rd(32'h0C, 32'h78, "small_cmpr_upper");
    rd(32'h20, 32'h0, "small_ch2_cr");
    rd(32'h2C, 32'h0, "small_ch2_cmpr");
    rd(32'h00, 32'hFF00, "small_cr_psc");
    rd(32'h100, 32'h0, "small_irq_pend");
    idle(2);
    checks++;
    if (irq2 !== 2'b0) begin
      errors++;
      $display("FAIL small_irq irq %b expected 00", irq2);
    end
    sel2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_single();
    test_halt();
    test_trg_hlt();
    test_retrigger();
    test_wrap();
    test_small();
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain pending %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
